// File: rtl/data_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : data_mem_responder
// Brief   : MEM-stage data memory with LATENCY wait states and pipeline stall.
// Revision: 1.0
// ----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd_MEM,
  input  logic        MemWr_MEM,
  input  logic [31:0] ALUout_MEM,
  input  logic [31:0] D_MEM,
  output logic        mem_stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_WAIT     = 2'd1;
  localparam logic [1:0] c_DONE     = 2'd2;
  localparam int         c_DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [3:0]        r_cnt;
  logic              r_rd;
  logic              r_wr;
  logic              r_bad;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_rdata_valid;
  logic              r_addr_err;
  logic [31:0]       r_mem [c_DEPTH];

  logic              w_req;
  logic              w_accept;
  logic              w_bad_in;
  logic              w_enter_done;
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic              w_sel_bad;
  logic [ADDR_W-1:0] w_sel_addr;

  assign w_req    = MemRd_MEM | MemWr_MEM;
  assign w_accept = (r_state == c_IDLE) && w_req;
  assign w_bad_in = |ALUout_MEM[31:ADDR_W];

  // With LATENCY=0 the DONE transition happens on the accept edge, so the
  // live inputs must be used before the latched copies exist.
  assign w_sel_rd   = (r_state == c_IDLE) ? MemRd_MEM : r_rd;
  assign w_sel_wr   = (r_state == c_IDLE) ? MemWr_MEM : r_wr;
  assign w_sel_bad  = (r_state == c_IDLE) ? w_bad_in : r_bad;
  assign w_sel_addr = (r_state == c_IDLE) ? ALUout_MEM[ADDR_W-1:0] : r_addr;

  assign w_enter_done = (w_state_next == c_DONE) && (r_state != c_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: if (w_req) w_state_next = (LATENCY > 0) ? c_WAIT : c_DONE;
      c_WAIT: if (r_cnt == 4'd0) w_state_next = c_DONE;
      c_DONE: w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = !reset && (w_accept || (r_state == c_WAIT));
  end

  // Load data and status pulses are registered on entry to DONE so they are
  // visible for exactly the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= 4'd0;
      r_rd          <= 1'b0;
      r_wr          <= 1'b0;
      r_bad         <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= 32'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd    <= MemRd_MEM;
        r_wr    <= MemWr_MEM;
        r_bad   <= w_bad_in;
        r_addr  <= ALUout_MEM[ADDR_W-1:0];
        r_wdata <= D_MEM;
        r_cnt   <= c_CNT_INIT;
      end else if (r_state == c_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_rdata_valid <= w_enter_done && w_sel_rd && !w_sel_wr;
      r_addr_err    <= w_enter_done && (w_sel_bad || (w_sel_rd && w_sel_wr));
      if (w_enter_done && w_sel_rd && !w_sel_wr) begin
        r_rdata <= w_sel_bad ? 32'd0 : r_mem[w_sel_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (r_state == c_DONE) && r_wr && !r_bad) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign addr_err    = r_addr_err;

endmodule
`default_nettype wire
